// File: rtl/regfile_mp_sb_pkg.sv
// Shared defaults and helpers for the multi-port register file with scoreboard.
// The address-width check in the top level uses clog2.
package regfile_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_DEPTH    = 32;
  localparam int DEF_AD_WIDTH = 5;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_mp_sb_if.sv
// Bundle of the register-file read, write and issue ports.
// The master drives addresses, data and issue; the slave returns read data, busy and the error flag.
interface regfile_mp_sb_if
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int AD_WIDTH = DEF_AD_WIDTH,
  parameter int NRD      = 2,
  parameter int NWR      = 2
);

  logic [NRD*AD_WIDTH-1:0] rd_addr;
  logic [NRD*WIDTH-1:0]    rd_data;
  logic [NRD-1:0]          rd_busy;
  logic [NWR-1:0]          wr_en;
  logic [NWR*AD_WIDTH-1:0] wr_addr;
  logic [NWR*WIDTH-1:0]    wr_data;
  logic                    iss_en;
  logic [AD_WIDTH-1:0]     iss_addr;
  logic                    wb_err;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    input  rd_data, rd_busy, wb_err
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    output rd_data, rd_busy, wb_err
  );

endinterface

// File: rtl/regfile_mp_sb_scoreboard.sv
// Write-pending scoreboard: one busy bit per register, set on issue and cleared on writeback.
// Also keeps the sticky flag for writebacks that hit a register with nothing pending.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AD_WIDTH = DEF_AD_WIDTH,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic                    iss_en,
  input  logic [AD_WIDTH-1:0]     iss_addr,
  input  logic [NWR-1:0]          wr_en,
  input  logic [NWR*AD_WIDTH-1:0] wr_addr,
  output logic [DEPTH-1:0]        busy,
  output logic                    wb_err
);

  localparam logic [AD_WIDTH:0] DEPTH_W = (AD_WIDTH+1)'(DEPTH);

  function automatic logic addr_valid(input logic [AD_WIDTH-1:0] a);
    return ({1'b0, a} < DEPTH_W) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  logic [DEPTH-1:0] busy_reg;
  logic [DEPTH-1:0] busy_next;
  logic             err_reg;
  logic             err_next;

  always_comb begin
    busy_next = busy_reg;
    err_next  = err_reg;
    for (int w = 0; w < NWR; w++) begin
      if (wr_en[w] && addr_valid(wr_addr[w*AD_WIDTH +: AD_WIDTH])) begin
        // Error is judged against the busy state held before this edge.
        if (!busy_reg[wr_addr[w*AD_WIDTH +: AD_WIDTH]]) begin
          err_next = 1'b1;
        end
        busy_next[wr_addr[w*AD_WIDTH +: AD_WIDTH]] = 1'b0;
      end
    end
    // Issue applied last so a new producer keeps the register busy.
    if (iss_en && addr_valid(iss_addr)) begin
      busy_next[iss_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      busy_reg <= '0;
      err_reg  <= 1'b0;
    end else begin
      busy_reg <= busy_next;
      err_reg  <= err_next;
    end
  end

  assign busy   = busy_reg;
  assign wb_err = err_reg;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with write-through bypass, optional hardwired r0,
// and a write-pending scoreboard feeding per-read-port stall indications.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AD_WIDTH = DEF_AD_WIDTH,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1
) (
  input logic            clk,
  input logic            res,
  regfile_mp_sb_if.slave bus
);

  localparam logic [AD_WIDTH:0] DEPTH_W = (AD_WIDTH+1)'(DEPTH);

  if (AD_WIDTH != clog2(DEPTH) || NRD < 1 || NRD > 4 || NWR < 1 || NWR > 2) begin : g_param_check
    $error("regfile_mp_sb: illegal parameter combination");
  end

  function automatic logic addr_valid(input logic [AD_WIDTH-1:0] a);
    return ({1'b0, a} < DEPTH_W) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  logic [WIDTH-1:0]    mem_reg [DEPTH];
  logic [AD_WIDTH-1:0] wr_a    [NWR];
  logic [WIDTH-1:0]    wr_d    [NWR];
  logic [NWR-1:0]      wr_ok;
  logic [DEPTH-1:0]    busy;

  genvar gi;

  // Bypass is suppressed while reset is held so reads are forced to zero.
  for (gi = 0; gi < NWR; gi++) begin : g_wr
    assign wr_a[gi]  = bus.wr_addr[gi*AD_WIDTH +: AD_WIDTH];
    assign wr_d[gi]  = bus.wr_data[gi*WIDTH +: WIDTH];
    assign wr_ok[gi] = res && bus.wr_en[gi] && addr_valid(wr_a[gi]);
  end

  // Ports are applied in ascending order, so the highest index wins a collision.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_ok[w]) begin
          mem_reg[wr_a[w]] <= wr_d[w];
        end
      end
    end
  end

  for (gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AD_WIDTH-1:0] rd_a;
    logic                rd_valid;
    logic                hit;
    logic [WIDTH-1:0]    byp;

    assign rd_a     = bus.rd_addr[gi*AD_WIDTH +: AD_WIDTH];
    assign rd_valid = addr_valid(rd_a);

    always_comb begin
      hit = 1'b0;
      byp = '0;
      for (int w = 0; w < NWR; w++) begin
        if (wr_ok[w] && (wr_a[w] == rd_a)) begin
          hit = 1'b1;
          byp = wr_d[w];
        end
      end
    end

    assign bus.rd_data[gi*WIDTH +: WIDTH] = !rd_valid ? '0 : (hit ? byp : mem_reg[rd_a]);
    assign bus.rd_busy[gi]                = rd_valid && busy[rd_a] && !hit;
  end

  regfile_scoreboard #(
    .DEPTH   (DEPTH),
    .AD_WIDTH(AD_WIDTH),
    .NWR     (NWR),
    .ZERO_REG(ZERO_REG)
  ) u_scoreboard (
    .clk     (clk),
    .res     (res),
    .iss_en  (bus.iss_en),
    .iss_addr(bus.iss_addr),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .busy    (busy),
    .wb_err  (bus.wb_err)
  );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: directed scenarios then random traffic, checked against a behavioural model.
// Two instances share stimulus: A has hardwired r0 and DEPTH 32, B has no r0 and DEPTH 24.
module tb_regfile_mp_sb;

  localparam int W   = 32;
  localparam int AW  = 5;
  localparam int NRD = 2;
  localparam int NWR = 2;

  logic clk = 1'b0;
  logic res = 1'b0;
  always #5 clk = ~clk;

  regfile_mp_sb_if #(.WIDTH(W), .AD_WIDTH(AW), .NRD(NRD), .NWR(NWR)) ifa ();
  regfile_mp_sb_if #(.WIDTH(W), .AD_WIDTH(AW), .NRD(NRD), .NWR(NWR)) ifb ();

  regfile_mp_sb #(.WIDTH(W), .DEPTH(32), .AD_WIDTH(AW), .NRD(NRD), .NWR(NWR), .ZERO_REG(1))
    dut_a (.clk(clk), .res(res), .bus(ifa.slave));
  regfile_mp_sb #(.WIDTH(W), .DEPTH(24), .AD_WIDTH(AW), .NRD(NRD), .NWR(NWR), .ZERO_REG(0))
    dut_b (.clk(clk), .res(res), .bus(ifb.slave));

  logic [AW-1:0]  t_ra [NRD];
  logic [NWR-1:0] t_we;
  logic [AW-1:0]  t_wa [NWR];
  logic [W-1:0]   t_wd [NWR];
  logic           t_ie;
  logic [AW-1:0]  t_ia;

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rp
    assign ifa.rd_addr[gi*AW +: AW] = t_ra[gi];
    assign ifb.rd_addr[gi*AW +: AW] = t_ra[gi];
  end
  for (genvar gi = 0; gi < NWR; gi++) begin : g_wp
    assign ifa.wr_addr[gi*AW +: AW] = t_wa[gi];
    assign ifb.wr_addr[gi*AW +: AW] = t_wa[gi];
    assign ifa.wr_data[gi*W +: W]   = t_wd[gi];
    assign ifb.wr_data[gi*W +: W]   = t_wd[gi];
  end
  assign ifa.wr_en    = t_we;
  assign ifb.wr_en    = t_we;
  assign ifa.iss_en   = t_ie;
  assign ifb.iss_en   = t_ie;
  assign ifa.iss_addr = t_ia;
  assign ifb.iss_addr = t_ia;

  // Reference model state, one set per instance.
  int          zr [2] = '{1, 0};
  int          dp [2] = '{32, 24};
  logic [31:0] m_mem  [2][32];
  bit          m_busy [2][32];
  bit          m_err  [2];

  int n_tests = 0;
  int n_fail  = 0;
  int n_cyc   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit addr_ok(input int k, input int a);
    return (a < dp[k]) && !((zr[k] != 0) && (a == 0));
  endfunction

  function automatic logic [31:0] exp_rd(input int k, input int p);
    int a;
    a = int'(t_ra[p]);
    if (!res || !addr_ok(k, a)) return 32'h0;
    for (int w = NWR - 1; w >= 0; w--) begin
      if (t_we[w] && int'(t_wa[w]) == a) return t_wd[w];
    end
    return m_mem[k][a];
  endfunction

  function automatic bit exp_busy(input int k, input int p);
    int a;
    a = int'(t_ra[p]);
    if (!res || !addr_ok(k, a)) return 1'b0;
    for (int w = 0; w < NWR; w++) begin
      if (t_we[w] && int'(t_wa[w]) == a) return 1'b0;
    end
    return m_busy[k][a];
  endfunction

  function automatic logic [31:0] got_rd(input int k, input int p);
    return (k == 0) ? ifa.rd_data[p*W +: W] : ifb.rd_data[p*W +: W];
  endfunction

  function automatic logic got_busy(input int k, input int p);
    return (k == 0) ? ifa.rd_busy[p] : ifb.rd_busy[p];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[k][i]  = 32'h0;
        m_busy[k][i] = 1'b0;
      end
      m_err[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < NWR; w++) begin
        if (t_we[w] && addr_ok(k, int'(t_wa[w])) && !m_busy[k][t_wa[w]]) m_err[k] = 1'b1;
      end
      for (int w = 0; w < NWR; w++) begin
        if (t_we[w] && addr_ok(k, int'(t_wa[w]))) begin
          m_mem[k][t_wa[w]]  = t_wd[w];
          m_busy[k][t_wa[w]] = 1'b0;
        end
      end
      if (t_ie && addr_ok(k, int'(t_ia))) m_busy[k][t_ia] = 1'b1;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < NRD; p++) begin
        chk($sformatf("rd_data%0d_p%0d", k, p), 64'(got_rd(k, p)), 64'(exp_rd(k, p)));
        chk($sformatf("rd_busy%0d_p%0d", k, p), 64'(got_busy(k, p)), 64'(exp_busy(k, p)));
      end
    end
    chk("wb_err_a", 64'(ifa.wb_err), 64'(m_err[0]));
    chk("wb_err_b", 64'(ifb.wb_err), 64'(m_err[1]));
  endtask

  task automatic idle();
    for (int p = 0; p < NRD; p++) t_ra[p] = '0;
    t_we = '0;
    for (int w = 0; w < NWR; w++) begin
      t_wa[w] = '0;
      t_wd[w] = '0;
    end
    t_ie = 1'b0;
    t_ia = '0;
  endtask

  task automatic step();
    #2;
    check_all();
    $display("[TB] cyc %0d ra=%0d,%0d we=%b wa=%0d,%0d wd=%h,%h iss=%b/%0d", n_cyc,
             t_ra[0], t_ra[1], t_we, t_wa[0], t_wa[1], t_wd[0], t_wd[1], t_ie, t_ia);
    @(posedge clk);
    model_edge();
    n_cyc++;
    #1;
  endtask

  task automatic do_reset();
    idle();
    res = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    res = 1'b1;
  endtask

  function automatic logic [AW-1:0] pick();
    return ($urandom_range(0, 9) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
  endfunction

  initial begin
    do_reset();
    t_ra[0] = 5'd3; t_ra[1] = 5'd20;
    step();

    // Hardwired r0 on A, ordinary r0 on B.
    idle(); t_we = 2'b01; t_wa[0] = 5'd0; t_wd[0] = 32'hFFFF_FFFF;
    #1;
    chk("zero_rd_a", 64'(got_rd(0, 0)), 64'h0);
    chk("zero_busy_a", 64'(got_busy(0, 0)), 64'h0);
    chk("zero_byp_b", 64'(got_rd(1, 0)), 64'hFFFF_FFFF);
    step();
    idle();
    #1;
    chk("zero_rd_b", 64'(got_rd(1, 0)), 64'hFFFF_FFFF);
    chk("zero_err_a", 64'(ifa.wb_err), 64'h0);
    step();

    // Issue r7, then writeback with bypass.
    idle(); t_ie = 1'b1; t_ia = 5'd7; t_ra[0] = 5'd7;
    #1; chk("iss7_same_cycle", 64'(got_busy(0, 0)), 64'h0);
    step();
    idle(); t_ra[0] = 5'd7;
    #1; chk("iss7_busy", 64'(got_busy(0, 0)), 64'h1);
    step();
    idle(); t_we = 2'b10; t_wa[1] = 5'd7; t_wd[1] = 32'h1234; t_ra[0] = 5'd7;
    #1;
    chk("wb7_busy", 64'(got_busy(0, 0)), 64'h0);
    chk("wb7_byp", 64'(got_rd(0, 0)), 64'h1234);
    step();
    idle(); t_ra[0] = 5'd7;
    #1;
    chk("wb7_after_busy", 64'(got_busy(0, 0)), 64'h0);
    chk("wb7_after_rd", 64'(got_rd(0, 0)), 64'h1234);
    chk("wb7_err", 64'(ifa.wb_err), 64'h0);
    step();

    // Issue and writeback of r9 in the same cycle: busy must survive.
    idle(); t_ie = 1'b1; t_ia = 5'd9;
    step();
    idle(); t_ie = 1'b1; t_ia = 5'd9; t_we = 2'b01; t_wa[0] = 5'd9; t_wd[0] = 32'h55;
    step();
    idle(); t_ra[0] = 5'd9;
    #1;
    chk("r9_still_busy", 64'(got_busy(0, 0)), 64'h1);
    chk("r9_err", 64'(ifa.wb_err), 64'h0);
    step();
    idle(); t_we = 2'b01; t_wa[0] = 5'd9; t_wd[0] = 32'h99;
    step();

    // Stray writeback to idle r3 raises the sticky error.
    idle(); t_we = 2'b01; t_wa[0] = 5'd3; t_wd[0] = 32'h33;
    #1; chk("r3_err_before", 64'(ifa.wb_err), 64'h0);
    step();
    idle(); t_ra[0] = 5'd3;
    #1;
    chk("r3_err_set", 64'(ifa.wb_err), 64'h1);
    chk("r3_rd", 64'(got_rd(0, 0)), 64'h33);
    step();
    idle(); t_we = 2'b11; t_wa[0] = 5'd4; t_wa[1] = 5'd6; t_wd[0] = 32'h4; t_wd[1] = 32'h6;
    step();
    idle();
    #1; chk("r3_err_sticky", 64'(ifa.wb_err), 64'h1);
    step();

    // Both ports write r5; port 1 wins.
    idle(); t_we = 2'b11; t_wa[0] = 5'd5; t_wa[1] = 5'd5;
    t_wd[0] = 32'hAAAA_0000; t_wd[1] = 32'h0000_BBBB; t_ra[0] = 5'd5; t_ra[1] = 5'd5;
    #1;
    chk("dual_byp_p0", 64'(got_rd(0, 0)), 64'h0000_BBBB);
    chk("dual_byp_p1", 64'(got_rd(0, 1)), 64'h0000_BBBB);
    step();
    idle(); t_ra[0] = 5'd5; t_ra[1] = 5'd7;
    #1; chk("dual_array", 64'(got_rd(0, 0)), 64'h0000_BBBB);
    step();

    // Asynchronous reset mid-cycle.
    idle(); t_ra[0] = 5'd5; t_ra[1] = 5'd7;
    #3;
    res = 1'b0;
    #1;
    chk("arst_rd_p0", 64'(got_rd(0, 0)), 64'h0);
    chk("arst_rd_p1", 64'(got_rd(0, 1)), 64'h0);
    chk("arst_err", 64'(ifa.wb_err), 64'h0);
    model_reset();
    check_all();
    @(posedge clk);
    @(negedge clk);
    res = 1'b1;

    // Random traffic concentrated on a few registers so hazards collide.
    for (int i = 0; i < 400; i++) begin
      if (i % 100 == 99) do_reset();
      for (int p = 0; p < NRD; p++) t_ra[p] = pick();
      t_we = NWR'($urandom_range(0, 3));
      for (int w = 0; w < NWR; w++) begin
        t_wa[w] = pick();
        t_wd[w] = $urandom();
      end
      t_ie = ($urandom_range(0, 2) == 0);
      t_ia = pick();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
